// File: rtl/bus_arbiter_if.sv
// Request/response bus between the arbiter (master) and the memory side (slave).
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                BusReqValid;
  logic                BusWrite;
  logic [ADDR_W-1:0]   BusAddr;
  logic [DATA_W-1:0]   BusWData;
  logic [DATA_W/8-1:0] BusWMask;
  logic                BusReqReady;
  logic                BusRspValid;
  logic [DATA_W-1:0]   BusRspData;

  modport master (
    output BusReqValid, BusWrite, BusAddr, BusWData, BusWMask,
    input  BusReqReady, BusRspValid, BusRspData
  );

  modport slave (
    input  BusReqValid, BusWrite, BusAddr, BusWData, BusWMask,
    output BusReqReady, BusRspValid, BusRspData
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one bus master port between fetch and LSU, one transaction in flight.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of LSU priority with fetch anti-starvation.
module bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                IfReqValid,
  input  logic [ADDR_W-1:0]   IfAddr,
  output logic                IfReqReady,
  input  logic                IfFlush,
  output logic                IfRspValid,
  output logic [DATA_W-1:0]   IfRspData,
  input  logic                LsReqValid,
  input  logic                LsWrite,
  input  logic [ADDR_W-1:0]   LsAddr,
  input  logic [DATA_W-1:0]   LsWData,
  input  logic [DATA_W/8-1:0] LsWMask,
  output logic                LsReqReady,
  output logic                LsRspValid,
  output logic [DATA_W-1:0]   LsRspData,
  bus_arbiter_if.master       Bus
);

  // state  | meaning
  // StIdle | arbitrate, grant at most one requester per cycle
  // StReq  | BusReqValid high, fields held until BusReqReady
  // StRsp  | waiting for BusRspValid
  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_t;
  typedef enum logic [1:0] {OwnNone, OwnFetch, OwnLsu} owner_t;

  state_t state, stateNext;
  owner_t owner;
  logic   dropFlag;
  logic   grantIf, grantLs;

  logic                busReqValidQ;
  logic                busWriteQ;
  logic [ADDR_W-1:0]   busAddrQ;
  logic [DATA_W-1:0]   busWDataQ;
  logic [DATA_W/8-1:0] busWMaskQ;
  logic                ifRspValidQ;
  logic [DATA_W-1:0]   ifRspDataQ;
  logic                lsRspValidQ;
  logic [DATA_W-1:0]   lsRspDataQ;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrantLs;
`else
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);
  logic [3:0] waitCnt;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= StIdle;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    grantIf   = 1'b0;
    grantLs   = 1'b0;
    case (state)
      StIdle: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (LsReqValid && IfReqValid) begin
          grantLs = !lastGrantLs;
          grantIf = lastGrantLs;
        end else begin
          grantLs = LsReqValid;
          grantIf = IfReqValid;
        end
`else
        if (LsReqValid && (waitCnt < MaxWait)) grantLs = 1'b1;
        else if (IfReqValid)                   grantIf = 1'b1;
`endif
        if (grantIf || grantLs) stateNext = StReq;
      end
      StReq:   if (Bus.BusReqReady) stateNext = StRsp;
      StRsp:   if (Bus.BusRspValid) stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
    if (Rst) begin
      grantIf = 1'b0;
      grantLs = 1'b0;
    end
  end

  assign IfReqReady = grantIf;
  assign LsReqReady = grantLs;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      busReqValidQ <= 1'b0;
      busWriteQ    <= 1'b0;
      busAddrQ     <= '0;
      busWDataQ    <= '0;
      busWMaskQ    <= '0;
      ifRspValidQ  <= 1'b0;
      ifRspDataQ   <= '0;
      lsRspValidQ  <= 1'b0;
      lsRspDataQ   <= '0;
      owner        <= OwnNone;
      dropFlag     <= 1'b0;
    end else begin
      ifRspValidQ <= 1'b0;
      lsRspValidQ <= 1'b0;
      case (state)
        StIdle: begin
          if (grantLs) begin
            busReqValidQ <= 1'b1;
            busWriteQ    <= LsWrite;
            busAddrQ     <= LsAddr;
            busWDataQ    <= LsWData;
            busWMaskQ    <= LsWMask;
            owner        <= OwnLsu;
          end else if (grantIf) begin
            busReqValidQ <= 1'b1;
            busWriteQ    <= 1'b0;
            busAddrQ     <= IfAddr;
            busWDataQ    <= '0;
            busWMaskQ    <= '0;
            owner        <= OwnFetch;
            dropFlag     <= IfFlush;
          end
        end
        StReq: begin
          if (owner == OwnFetch && IfFlush) dropFlag <= 1'b1;
          if (Bus.BusReqReady) busReqValidQ <= 1'b0;
        end
        StRsp: begin
          if (owner == OwnFetch && IfFlush) dropFlag <= 1'b1;
          if (Bus.BusRspValid) begin
            // A flush arriving together with the response still discards it.
            if (owner == OwnFetch && !(dropFlag || IfFlush)) begin
              ifRspValidQ <= 1'b1;
              ifRspDataQ  <= Bus.BusRspData;
            end
            if (owner == OwnLsu) begin
              lsRspValidQ <= 1'b1;
              lsRspDataQ  <= busWriteQ ? '0 : Bus.BusRspData;
            end
            owner    <= OwnNone;
            dropFlag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge Clk) begin
    if (Rst)          lastGrantLs <= 1'b0;
    else if (grantIf) lastGrantLs <= 1'b0;
    else if (grantLs) lastGrantLs <= 1'b1;
  end
`else
  always_ff @(posedge Clk) begin
    if (Rst) begin
      waitCnt <= '0;
    end else if (state == StIdle) begin
      if (!IfReqValid || grantIf)              waitCnt <= '0;
      else if (grantLs && (waitCnt < MaxWait)) waitCnt <= waitCnt + 4'd1;
    end
  end
`endif

  assign Bus.BusReqValid = busReqValidQ;
  assign Bus.BusWrite    = busWriteQ;
  assign Bus.BusAddr     = busAddrQ;
  assign Bus.BusWData    = busWDataQ;
  assign Bus.BusWMask    = busWMaskQ;
  assign IfRspValid      = ifRspValidQ;
  assign IfRspData       = ifRspDataQ;
  assign LsRspValid      = lsRspValidQ;
  assign LsRspData       = lsRspDataQ;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: table of single transactions plus hand-written multi-cycle sequences.
module tb_bus_arbiter;
  logic        Clk = 1'b0;
  logic        Rst;
  logic        IfReqValid, IfReqReady, IfFlush, IfRspValid;
  logic [31:0] IfAddr, IfRspData;
  logic        LsReqValid, LsWrite, LsReqReady, LsRspValid;
  logic [31:0] LsAddr, LsWData, LsRspData;
  logic [3:0]  LsWMask;

  int total = 0;
  int bad   = 0;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .IfReqValid(IfReqValid), .IfAddr(IfAddr), .IfReqReady(IfReqReady), .IfFlush(IfFlush),
    .IfRspValid(IfRspValid), .IfRspData(IfRspData),
    .LsReqValid(LsReqValid), .LsWrite(LsWrite), .LsAddr(LsAddr), .LsWData(LsWData),
    .LsWMask(LsWMask), .LsReqReady(LsReqReady), .LsRspValid(LsRspValid), .LsRspData(LsRspData),
    .Bus(bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          ifv;
    logic [31:0] ifAddr;
    bit          flushGrant;
    bit          lsv;
    bit          lsw;
    logic [31:0] lsAddr;
    logic [31:0] lsWData;
    logic [3:0]  lsMask;
    logic [31:0] busData;
    bit          expIf;
    logic [31:0] expAddr;
    bit          expWrite;
    logic [31:0] expWData;
    logic [3:0]  expMask;
    int          reqWait;
    int          rspWait;
    bit          flushRsp;
    bit          expRsp;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic resetDut();
    Rst = 1'b1;
    IfReqValid = 0; IfAddr = '0; IfFlush = 0;
    LsReqValid = 0; LsWrite = 0; LsAddr = '0; LsWData = '0; LsWMask = '0;
    bus.BusReqReady = 0; bus.BusRspValid = 0; bus.BusRspData = '0;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic chkAllZero(input string name);
    chk(name, 64'({|IfRspData, |LsRspData, |bus.BusAddr, |bus.BusWData, |bus.BusWMask,
                   IfReqReady, LsReqReady, IfRspValid, LsRspValid, bus.BusReqValid, bus.BusWrite}), 64'd0);
  endtask

  task automatic applyIn(input vec_t v);
    IfReqValid = v.ifv;  IfAddr = v.ifAddr; IfFlush = v.flushGrant;
    LsReqValid = v.lsv;  LsWrite = v.lsw;   LsAddr = v.lsAddr;
    LsWData = v.lsWData; LsWMask = v.lsMask;
  endtask

  // Entered with the DUT in IDLE and requests applied; returns in the IDLE cycle carrying the response.
  task automatic doTxn(input vec_t v, input bit drop);
    #1;
    chk("ifReqReady", 64'(IfReqReady), 64'(v.expIf));
    chk("lsReqReady", 64'(LsReqReady), 64'(!v.expIf));
    tick();
    IfFlush = 0;
    if (drop) begin
      if (v.expIf) IfReqValid = 0;
      else         LsReqValid = 0;
    end
    chk("busReqValid", 64'(bus.BusReqValid), 64'd1);
    chk("busAddr", 64'(bus.BusAddr), 64'(v.expAddr));
    chk("busWrite", 64'(bus.BusWrite), 64'(v.expWrite));
    chk("busWMask", 64'(bus.BusWMask), 64'(v.expMask));
    if (!v.expIf) chk("busWData", 64'(bus.BusWData), 64'(v.expWData));
    for (int i = 0; i < v.reqWait; i++) begin
      tick();
      chk("busReqHold", 64'({bus.BusReqValid, bus.BusAddr}), 64'({1'b1, v.expAddr}));
    end
    bus.BusReqReady = 1;
    tick();
    bus.BusReqReady = 0;
    chk("busReqDrop", 64'(bus.BusReqValid), 64'd0);
    IfFlush = v.flushRsp;
    for (int i = 0; i < v.rspWait; i++) begin
      tick();
      IfFlush = 0;
      chk("rspEarly", 64'({IfRspValid, LsRspValid}), 64'd0);
    end
    bus.BusRspValid = 1;
    bus.BusRspData  = v.busData;
    tick();
    bus.BusRspValid = 0;
    IfFlush = 0;
    chk("ifRspValid", 64'(IfRspValid), 64'(v.expIf & v.expRsp));
    chk("lsRspValid", 64'(LsRspValid), 64'(!v.expIf));
    if (v.expIf && v.expRsp) chk("ifRspData", 64'(IfRspData), 64'(v.expData));
    if (!v.expIf) chk("lsRspData", 64'(LsRspData), 64'(v.expData));
  endtask

  initial begin
    vec_t f, s;

    vecs[0] = '{ifv:1, ifAddr:32'h8000_0000, flushGrant:0, lsv:0, lsw:0, lsAddr:0, lsWData:0, lsMask:0,
                busData:32'h0000_0013, expIf:1, expAddr:32'h8000_0000, expWrite:0, expWData:0, expMask:0,
                reqWait:1, rspWait:1, flushRsp:0, expRsp:1, expData:32'h0000_0013};
    vecs[1] = '{ifv:0, ifAddr:0, flushGrant:0, lsv:1, lsw:0, lsAddr:32'h8000_1000, lsWData:0, lsMask:4'hF,
                busData:32'hDEAD_BEEF, expIf:0, expAddr:32'h8000_1000, expWrite:0, expWData:0, expMask:4'hF,
                reqWait:0, rspWait:0, flushRsp:0, expRsp:1, expData:32'hDEAD_BEEF};
    vecs[2] = '{ifv:0, ifAddr:0, flushGrant:0, lsv:1, lsw:1, lsAddr:32'h8000_2000, lsWData:32'h1122_3344,
                lsMask:4'h3, busData:32'hA5A5_A5A5, expIf:0, expAddr:32'h8000_2000, expWrite:1,
                expWData:32'h1122_3344, expMask:4'h3, reqWait:2, rspWait:2, flushRsp:0, expRsp:1, expData:0};
    vecs[3] = '{ifv:1, ifAddr:32'h8000_0000, flushGrant:0, lsv:1, lsw:0, lsAddr:32'h8000_1000, lsWData:0,
                lsMask:4'hF, busData:32'h1234_5678, expIf:0, expAddr:32'h8000_1000, expWrite:0, expWData:0,
                expMask:4'hF, reqWait:0, rspWait:1, flushRsp:0, expRsp:1, expData:32'h1234_5678};
    vecs[4] = '{ifv:1, ifAddr:32'h8000_0040, flushGrant:1, lsv:0, lsw:0, lsAddr:0, lsWData:0, lsMask:0,
                busData:32'h0000_0055, expIf:1, expAddr:32'h8000_0040, expWrite:0, expWData:0, expMask:0,
                reqWait:0, rspWait:1, flushRsp:0, expRsp:0, expData:0};
    vecs[5] = '{ifv:1, ifAddr:32'h8000_0080, flushGrant:0, lsv:0, lsw:0, lsAddr:0, lsWData:0, lsMask:0,
                busData:32'h0000_0066, expIf:1, expAddr:32'h8000_0080, expWrite:0, expWData:0, expMask:0,
                reqWait:0, rspWait:0, flushRsp:1, expRsp:0, expData:0};

    for (int i = 0; i < 6; i++) begin
      resetDut();
      if (i == 0) chkAllZero("resetZero");
      applyIn(vecs[i]);
      doTxn(vecs[i], 1'b1);
    end

    // Both request: LSU first, fetch granted in the IDLE cycle carrying the LSU response.
    resetDut();
    applyIn(vecs[3]);
    doTxn(vecs[3], 1'b1);
    doTxn(vecs[0], 1'b1);

    // Continuous store stream with fetch pending.
    resetDut();
    f = vecs[0];
    f.reqWait = 0;
    f.rspWait = 0;
    s = vecs[2];
    s.lsAddr = 32'h8000_3000; s.expAddr = 32'h8000_3000;
    s.lsWData = 32'hCAFE_F00D; s.expWData = 32'hCAFE_F00D;
    s.lsMask = 4'hF; s.expMask = 4'hF;
    s.busData = 32'hFFFF_FFFF; s.expData = 32'h0;
    s.reqWait = 0; s.rspWait = 0;
    IfReqValid = 1; IfAddr = f.ifAddr;
    LsReqValid = 1; LsWrite = 1; LsAddr = s.lsAddr; LsWData = s.lsWData; LsWMask = s.lsMask;
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) doTxn(s, 1'b0);
      else            doTxn(f, 1'b0);
    end
`else
    for (int i = 0; i < 6; i++) begin
      if (i == 4) doTxn(f, 1'b1);
      else        doTxn(s, 1'b0);
    end
`endif
    IfReqValid = 0;
    LsReqValid = 0;

    // Flush during RSP, then a new fetch is served normally.
    resetDut();
    f = vecs[0];
    f.flushRsp = 1; f.expRsp = 0;
    applyIn(f);
    doTxn(f, 1'b1);
    f = vecs[0];
    f.ifAddr = 32'h8000_0100; f.expAddr = 32'h8000_0100;
    f.busData = 32'h0000_0297; f.expData = 32'h0000_0297;
    applyIn(f);
    doTxn(f, 1'b1);

    // Reset while in REQ.
    resetDut();
    applyIn(vecs[0]);
    #1;
    chk("rstIfReqReady", 64'(IfReqReady), 64'd1);
    tick();
    IfReqValid = 0;
    chk("rstBusReqValid", 64'(bus.BusReqValid), 64'd1);
    Rst = 1;
    tick();
    Rst = 0;
    chkAllZero("rstMidZero");
    applyIn(vecs[0]);
    doTxn(vecs[0], 1'b1);

    // Stray response and flush while IDLE are ignored.
    tick();
    IfFlush = 1;
    bus.BusRspValid = 1;
    bus.BusRspData = 32'h7777_7777;
    tick();
    IfFlush = 0;
    bus.BusRspValid = 0;
    chk("strayRsp", 64'({IfRspValid, LsRspValid}), 64'd0);
    applyIn(vecs[0]);
    doTxn(vecs[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single instruction/data bus master port between the fetch requester (pre-PC fetch stage) and the load/store unit.
- One transaction outstanding at a time; blocking request/response sequencing.
- Fixed LSU priority with fetch anti-starvation.
- Supports discard of an in-flight fetch response on a pipeline jump.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- MAX_WAIT, 4, consecutive lost arbitrations before fetch is forced to win (1..15).

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous reset, active-high
- IfReqValid  in  1  fetch request
- IfAddr  in  ADDR_W  fetch address
- IfReqReady  out  1  fetch request accepted (1-cycle pulse)
- IfFlush  in  1  jump: discard outstanding fetch response
- IfRspValid  out  1  fetch data valid (1-cycle pulse)
- IfRspData  out  DATA_W  fetch data
- LsReqValid  in  1  LSU request
- LsWrite  in  1  1=store, 0=load
- LsAddr  in  ADDR_W  LSU address
- LsWData  in  DATA_W  store data
- LsWMask  in  DATA_W/8  byte strobes
- LsReqReady  out  1  LSU request accepted (1-cycle pulse)
- LsRspValid  out  1  load data / store ack (1-cycle pulse)
- LsRspData  out  DATA_W  load data (0 for store)
- BusReqValid  out  1  bus request
- BusWrite, BusAddr, BusWData, BusWMask  out  1/ADDR_W/DATA_W/DATA_W/8  bus request fields
- BusReqReady  in  1  bus accepts request
- BusRspValid  in  1  bus response
- BusRspData  in  DATA_W  bus read data

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; WaitCnt=0; Owner=NONE; DropFlag=0.
- IDLE, arbitration each cycle:
  - LsReqValid and WaitCnt<MAX_WAIT: grant LSU.
  - Else IfReqValid: grant fetch.
  - Else stay IDLE.
- On grant:
  - Pulse the granted XxReqReady combinationally in the same cycle.
  - Latch the requester's fields into the Bus* output registers.
  - Set Owner; go to REQ.
  - Fetch grant forces BusWrite=0 and BusWMask=0.
- WaitCnt:
  - Increments (saturating at MAX_WAIT) on each LSU grant made while IfReqValid=1.
  - Clears on each fetch grant.
  - Clears in any IDLE cycle with IfReqValid=0.
- REQ:
  - BusReqValid=1 with fields held stable until BusReqReady=1.
  - Then BusReqValid<=0 and go to RSP.
- RSP:
  - Wait for BusRspValid.
  - On the cycle it arrives, go to IDLE.
  - Next cycle the owner's XxRspValid=1 and XxRspData<=BusRspData (registered, 1-cycle latency).
  - Arbitration may grant again in that same IDLE cycle.
- Minimum transaction time: grant→BusReqValid 1 cycle; BusRspValid→RspValid 1 cycle.
- IfFlush:
  - While Owner=fetch in REQ or RSP: set DropFlag. The bus transaction still completes (no abort), but IfRspValid is suppressed.
  - In IDLE: no effect.
  - On the grant cycle: the flush applies to the just-granted fetch.
  - DropFlag clears on return to IDLE.
- BusRspValid outside RSP: ignored.
- BusReqReady and BusRspValid in the same REQ cycle: RSP-entry response is not supported; the bus must respond ≥1 cycle after accept.
- Rst mid-transaction: immediate return to IDLE; no response is forwarded; the bus side is the responsibility of the system reset.
- No request queuing. Requesters hold XxReqValid and fields until XxReqReady.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined:
  - Fixed priority and WaitCnt are replaced by a 1-bit LastGrant register (reset = fetch).
  - When both request, grant the requester not in LastGrant. LastGrant updates on every grant.
  - MAX_WAIT is unused.
- Undefined: fixed LSU priority with MAX_WAIT anti-starvation as above.

Test Plan:
- Fetch alone, IfAddr=0x80000000, bus ready 1 cycle, data 0x00000013 after 2 cycles:
  - IfReqReady pulse at cycle 0; BusReqValid cycles 1–2; IfRspValid with 0x00000013 one cycle after BusRspValid.
- Simultaneous IfReqValid and LsReqValid (load 0x80001000):
  - LSU granted first; fetch granted in the IDLE cycle after the LSU response; WaitCnt=1 then 0.
- LsReqValid held continuously with a store stream and IfReqValid=1, MAX_WAIT=4:
  - Exactly 4 LSU grants, then a fetch grant.
  - LsRspValid for stores with LsRspData=0.
- Fetch outstanding, IfFlush pulsed during RSP:
  - Bus transaction completes; IfRspValid stays 0.
  - Next fetch (new address 0x80000100) is served normally.
- Rst asserted during REQ:
  - Next cycle all outputs 0, state IDLE.
  - Subsequent fetch behaves as the first scenario.
- With ARB_ROUND_ROBIN_EN, both requesting continuously:
  - Grants alternate fetch/LSU, starting with LSU after reset.
